// File: rtl/aes_mix_columns_serial.sv
// Sequential AES MixColumns / InvMixColumns over a 128-bit state, ColsPerCycle
// columns per clock through shared single-column mixers, valid/ready on both sides.

module aes_mix_single_column (
    input  logic [1:0]      op_i,
    input  logic [3:0][7:0] data_i,
    output logic [3:0][7:0] data_o
);
    localparam logic [1:0] CIPH_FWD = 2'b01;
    localparam logic [1:0] CIPH_INV = 2'b10;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [3:0][7:0] m2, m3, m4, m8, m9, mb, md, me;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            m2[r] = xt(data_i[r]);
            m3[r] = m2[r] ^ data_i[r];
            m4[r] = xt(m2[r]);
            m8[r] = xt(m4[r]);
            m9[r] = m8[r] ^ data_i[r];
            mb[r] = m8[r] ^ m2[r] ^ data_i[r];
            md[r] = m8[r] ^ m4[r] ^ data_i[r];
            me[r] = m8[r] ^ m4[r] ^ m2[r];
        end
    end

    // Unrecognised op selects no terms, so the column mixes to zero.
    always_comb begin
        data_o = '0;
        for (int r = 0; r < 4; r++) begin
            if (op_i == CIPH_FWD) begin
                data_o[r] = m2[r] ^ m3[2'(r + 1)] ^ data_i[2'(r + 2)] ^ data_i[2'(r + 3)];
            end else if (op_i == CIPH_INV) begin
                data_o[r] = me[r] ^ mb[2'(r + 1)] ^ md[2'(r + 2)] ^ m9[2'(r + 3)];
            end
        end
    end
endmodule

module aes_mix_columns_serial #(
    parameter int ColsPerCycle   = 1,
    parameter bit SecClearOutput = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [1:0]           op_i,
    input  logic [3:0][3:0][7:0] state_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [3:0][3:0][7:0] state_o,
    output logic                 op_err_o
);
    // state | meaning
    // IDLE  | ready for a new state
    // BUSY  | mixing ColsPerCycle columns per cycle in place
    // DONE  | result presented, waiting for out_ready_i

    localparam int NumPasses = 4 / ColsPerCycle;
    localparam int CntW      = (NumPasses > 1) ? $clog2(NumPasses) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(NumPasses - 1);
    localparam logic [1:0] CIPH_FWD = 2'b01;
    localparam logic [1:0] CIPH_INV = 2'b10;

    generate
        if (ColsPerCycle != 1 && ColsPerCycle != 2 && ColsPerCycle != 4) begin : g_bad_cols
            $error("ColsPerCycle must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_e;

    fsm_e                 fsm_q, fsm_d;
    logic [3:0][3:0][7:0] st_q;
    logic [1:0]           op_q;
    logic [CntW-1:0]      cnt_q;
    logic                 err_q;
    logic                 accept, step, handoff;

    logic [1:0]      col_sel [ColsPerCycle];
    logic [3:0][7:0] mix_in  [ColsPerCycle];
    logic [3:0][7:0] mix_out [ColsPerCycle];

    always_comb begin
        for (int k = 0; k < ColsPerCycle; k++) begin
            col_sel[k] = 2'(int'(cnt_q) * ColsPerCycle + k);
            for (int r = 0; r < 4; r++) begin
                mix_in[k][r] = st_q[r][col_sel[k]];
            end
        end
    end

    generate
        for (genvar k = 0; k < ColsPerCycle; k++) begin : g_mix
            aes_mix_single_column u_mix (
                .op_i   (op_q),
                .data_i (mix_in[k]),
                .data_o (mix_out[k])
            );
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) fsm_q <= IDLE;
        else                  fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d       = fsm_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        accept      = 1'b0;
        step        = 1'b0;
        handoff     = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i && !clear_i) begin
                    accept = 1'b1;
                    fsm_d  = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (cnt_q == CntLast) fsm_d = DONE;
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    handoff = 1'b1;
                    fsm_d   = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
        if (clear_i) fsm_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            st_q  <= '0;
            op_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            st_q  <= state_i;
            op_q  <= op_i;
            cnt_q <= '0;
            err_q <= (op_i != CIPH_FWD) && (op_i != CIPH_INV);
        end else if (step) begin
            for (int k = 0; k < ColsPerCycle; k++) begin
                for (int r = 0; r < 4; r++) begin
                    st_q[r][col_sel[k]] <= mix_out[k][r];
                end
            end
            cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
        end else if (handoff) begin
            err_q <= 1'b0;
            if (SecClearOutput) st_q <= '0;
        end
    end

    assign state_o  = err_q ? '0 : st_q;
    assign op_err_o = err_q && (fsm_q == DONE);
endmodule
